inst_mem_resp: RTL and testbench

Responder end of the CPU instruction-fetch interface: a synchronous, loadable instruction memory that answers `LA_cpu` fetch requests with registered data one cycle later. It replaces the combinational `inst_rom` in the SoC top level. It adds a program-load write port, a boot/run state machine, and error flagging for bad fetch addresses.

---
 rtl/inst_mem_resp_pkg.sv | 18 +
 rtl/inst_ram_sdp.sv | 34 +++
 rtl/inst_mem_resp.sv | 121 ++++++++++++
 tb/tb_inst_mem_resp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_resp_pkg.sv
// Shared definitions for the instruction-fetch responder.
// Holds the default widths, the erroneous-fetch filler word and the
// boot/run state encoding.
package inst_mem_resp_pkg;

    localparam int unsigned INST_ADDR_WIDTH = 32;
    localparam int unsigned INST_WIDTH      = 32;
    localparam int unsigned INST_DEPTH_LOG2 = 10;

    // LoongArch "andi r0,r0,0", returned in place of data on a bad fetch
    localparam logic [31:0] NOP_INST_WORD = 32'h0340_0000;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/inst_ram_sdp.sv
// Simple dual-port RAM: one synchronous write port and one registered,
// read-first read port. Contents are never reset.
// Ports:
//   clk            rising-edge clock
//   wr_en/wr_addr/wr_data   word write
//   rd_en/rd_addr           read request, data on rd_data one cycle later
module inst_ram_sdp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-first: a same-cycle write to rd_addr is not visible to this read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_resp.sv
// Loadable instruction memory answering CPU fetches with registered data
// one cycle after acceptance.
// Ports:
//   clk, rst (synchronous, active-low)
//   rom_inst_en/rom_inst_addr      fetch request (accepted when rom_inst_ready)
//   rom_inst/rom_inst_valid/rom_inst_err   fetch response, one cycle later
//   rom_inst_ready                 high only in RUN
//   load_en/load_addr/load_data/load_last  program-load write port
//   load_done                      one-cycle pulse after a load_last write
//   load_count                     words written in the current load session
module inst_mem_resp
    import inst_mem_resp_pkg::*;
#(
    parameter int unsigned       ADDR_W     = INST_ADDR_WIDTH,
    parameter int unsigned       DATA_W     = INST_WIDTH,
    parameter int unsigned       DEPTH_LOG2 = INST_DEPTH_LOG2,
    parameter logic [DATA_W-1:0] NOP_INST   = DATA_W'(NOP_INST_WORD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_inst_en,
    input  logic [ADDR_W-1:0]     rom_inst_addr,
    output logic [DATA_W-1:0]     rom_inst,
    output logic                  rom_inst_valid,
    output logic                  rom_inst_err,
    output logic                  rom_inst_ready,
    input  logic                  load_en,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  load_last,
    output logic                  load_done,
    output logic [DEPTH_LOG2:0]   load_count
);

    localparam int unsigned      CNT_W   = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t            state, state_next;
    logic              ready_next;
    logic              done_next;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  count_base;

    logic              fetch_acc;
    logic              fetch_bad;
    logic              load_bad;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    // Address checks: word alignment and upper bits beyond the array
    assign fetch_bad = (rom_inst_addr[1:0] != 2'b00)
                     || (rom_inst_addr[ADDR_W-1:DEPTH_LOG2+2] != '0);
    assign load_bad  = (load_addr[1:0] != 2'b00)
                     || (load_addr[ADDR_W-1:DEPTH_LOG2+2] != '0);

    // ready mirrors the registered state, so it also gates fetch acceptance
    assign fetch_acc = rom_inst_ready && rom_inst_en;
    assign wr_en     = load_en && !load_bad;

    inst_ram_sdp #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (load_addr[DEPTH_LOG2+1:2]),
        .wr_data (load_data),
        .rd_en   (fetch_acc && !fetch_bad),
        .rd_addr (rom_inst_addr[DEPTH_LOG2+1:2]),
        .rd_data (rd_data)
    );

    // Next state, load bookkeeping
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        count_next = load_count;
        count_base = load_count;

        unique case (state)
            ST_LOAD: if (load_en && load_last)  state_next = ST_RUN;
            ST_RUN:  if (load_en && !load_last) state_next = ST_LOAD;
        endcase

        if (load_en) begin
            done_next = load_last;
            // A write arriving in RUN opens a new session and is its first word
            if (state == ST_RUN) begin
                count_base = '0;
            end
            count_next = (count_base == CNT_MAX) ? CNT_MAX : count_base + CNT_W'(1);
        end

        ready_next = (state_next == ST_RUN);
    end

    // State, handshake and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_LOAD;
            rom_inst_ready <= 1'b0;
            load_done      <= 1'b0;
            load_count     <= '0;
            rom_inst_valid <= 1'b0;
            rom_inst_err   <= 1'b0;
        end else begin
            state          <= state_next;
            rom_inst_ready <= ready_next;
            load_done      <= done_next;
            load_count     <= count_next;
            rom_inst_valid <= fetch_acc;
            rom_inst_err   <= fetch_acc && fetch_bad;
        end
    end

    // RAM data is not reset, so the word is only driven while a response is live
    assign rom_inst = !rom_inst_valid ? '0
                    : rom_inst_err    ? NOP_INST
                    :                   rd_data;

endmodule

// File: tb/tb_inst_mem_resp.sv
module tb_inst_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_inst_en;
    logic [31:0] rom_inst_addr;
    logic [31:0] rom_inst;
    logic        rom_inst_valid;
    logic        rom_inst_err;
    logic        rom_inst_ready;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_done;
    logic [10:0] load_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_mem_resp dut (
        .clk            (clk),
        .rst            (rst),
        .rom_inst_en    (rom_inst_en),
        .rom_inst_addr  (rom_inst_addr),
        .rom_inst       (rom_inst),
        .rom_inst_valid (rom_inst_valid),
        .rom_inst_err   (rom_inst_err),
        .rom_inst_ready (rom_inst_ready),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_done      (load_done),
        .load_count     (load_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic en, input logic [31:0] addr);
        rom_inst_en   = en;
        rom_inst_addr = addr;
    endtask

    task automatic set_load(input logic en, input logic [31:0] addr,
                            input logic [31:0] data, input logic last);
        load_en   = en;
        load_addr = addr;
        load_data = data;
        load_last = last;
    endtask

    initial begin
        rst = 1'b0;
        set_fetch(1'b0, 32'h0);
        set_load(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        check("rst_inst",  rom_inst, 32'h0);
        check("rst_valid", 32'(rom_inst_valid), 32'h0);
        check("rst_err",   32'(rom_inst_err), 32'h0);
        check("rst_ready", 32'(rom_inst_ready), 32'h0);
        check("rst_done",  32'(load_done), 32'h0);
        check("rst_count", 32'(load_count), 32'h0);

        // Program load, with a fetch attempted while not ready
        rst = 1'b1;
        set_load(1'b1, 32'h0, 32'hA0, 1'b0);
        tick();
        check("load0_done",  32'(load_done), 32'h0);
        check("load0_count", 32'(load_count), 32'h1);
        set_load(1'b1, 32'h4, 32'hA1, 1'b0);
        set_fetch(1'b1, 32'h0);
        tick();
        check("notready_valid", 32'(rom_inst_valid), 32'h0);
        check("notready_ready", 32'(rom_inst_ready), 32'h0);
        set_fetch(1'b0, 32'h0);
        set_load(1'b1, 32'h8, 32'hA2, 1'b0);
        tick();
        set_load(1'b1, 32'hC, 32'hA3, 1'b1);
        tick();
        check("last_done",  32'(load_done), 32'h1);
        check("last_count", 32'(load_count), 32'h4);
        check("last_ready", 32'(rom_inst_ready), 32'h1);

        // Back-to-back fetch stream
        set_load(1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b1, 32'h0);
        tick();
        check("done_pulse", 32'(load_done), 32'h0);
        check("f0_inst",  rom_inst, 32'hA0);
        check("f0_valid", 32'(rom_inst_valid), 32'h1);
        check("f0_err",   32'(rom_inst_err), 32'h0);
        set_fetch(1'b1, 32'h4);
        tick();
        check("f1_inst",  rom_inst, 32'hA1);
        check("f1_valid", 32'(rom_inst_valid), 32'h1);
        set_fetch(1'b1, 32'h8);
        tick();
        check("f2_inst",  rom_inst, 32'hA2);
        check("f2_valid", 32'(rom_inst_valid), 32'h1);
        set_fetch(1'b1, 32'hC);
        tick();
        check("f3_inst",  rom_inst, 32'hA3);
        check("f3_err",   32'(rom_inst_err), 32'h0);

        // Misaligned then out-of-range fetch
        set_fetch(1'b1, 32'h2);
        tick();
        check("mis_inst",  rom_inst, 32'h0340_0000);
        check("mis_valid", 32'(rom_inst_valid), 32'h1);
        check("mis_err",   32'(rom_inst_err), 32'h1);
        set_fetch(1'b1, 32'h1000);
        tick();
        check("oor_inst",  rom_inst, 32'h0340_0000);
        check("oor_valid", 32'(rom_inst_valid), 32'h1);
        check("oor_err",   32'(rom_inst_err), 32'h1);
        set_fetch(1'b0, 32'h0);
        tick();
        check("idle_valid", 32'(rom_inst_valid), 32'h0);

        // load_last on the write that would leave RUN: stays RUN, read-first
        set_fetch(1'b1, 32'hC);
        set_load(1'b1, 32'hC, 32'hD3, 1'b1);
        tick();
        check("runlast_inst",  rom_inst, 32'hA3);
        check("runlast_ready", 32'(rom_inst_ready), 32'h1);
        check("runlast_done",  32'(load_done), 32'h1);
        set_load(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check("runlast_new", rom_inst, 32'hD3);

        // Collision: fetch and write word 1 in the same cycle
        set_fetch(1'b1, 32'h4);
        set_load(1'b1, 32'h4, 32'hBB, 1'b0);
        tick();
        check("col_inst",  rom_inst, 32'hA1);
        check("col_valid", 32'(rom_inst_valid), 32'h1);
        check("col_ready", 32'(rom_inst_ready), 32'h0);
        // Out-of-range write aliasing word 1 must be dropped
        set_load(1'b1, 32'h1004, 32'hDEAD, 1'b0);
        tick();
        check("load_fetch_valid", 32'(rom_inst_valid), 32'h0);
        set_fetch(1'b0, 32'h0);
        set_load(1'b1, 32'h8, 32'hC2, 1'b1);
        tick();
        check("reload_done",  32'(load_done), 32'h1);
        check("reload_ready", 32'(rom_inst_ready), 32'h1);
        set_load(1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b1, 32'h4);
        tick();
        check("col_new_inst", rom_inst, 32'hBB);
        set_fetch(1'b1, 32'h8);
        tick();
        check("reload_inst", rom_inst, 32'hC2);

        // Reset while a response is outstanding
        set_fetch(1'b1, 32'h0);
        rst = 1'b0;
        tick();
        check("mid_valid", 32'(rom_inst_valid), 32'h0);
        check("mid_inst",  rom_inst, 32'h0);
        check("mid_err",   32'(rom_inst_err), 32'h0);
        check("mid_ready", 32'(rom_inst_ready), 32'h0);
        check("mid_done",  32'(load_done), 32'h0);
        check("mid_count", 32'(load_count), 32'h0);
        rst = 1'b1;
        tick();
        check("post_rst_valid0", 32'(rom_inst_valid), 32'h0);
        tick();
        check("post_rst_valid1", 32'(rom_inst_valid), 32'h0);
        set_fetch(1'b0, 32'h0);
        set_load(1'b1, 32'h10, 32'hE4, 1'b1);
        tick();
        check("post_rst_ready", 32'(rom_inst_ready), 32'h1);
        set_load(1'b0, 32'h0, 32'h0, 1'b0);
        set_fetch(1'b1, 32'h0);
        tick();
        check("mem_kept", rom_inst, 32'hA0);
        set_fetch(1'b1, 32'h10);
        tick();
        check("post_rst_inst", rom_inst, 32'hE4);
        set_fetch(1'b0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
